// File: rtl/ene_formation.sv
// Enemy formation engine: a ROWS x COLS block of square enemies that marches sideways, drops at
// the walls, dies to bullet pixels during scanout and respawns as a new wave after a clear.
module ene_formation #(
  parameter int COLS     = 6,
  parameter int ROWS     = 2,
  parameter int ESIZE    = 21,
  parameter int X_PITCH  = 50,
  parameter int Y_PITCH  = 100,
  parameter int X0       = 30,
  parameter int Y0       = 100,
  parameter int STEP     = 2,
  parameter int DROP     = 10,
  parameter int XMIN     = 5,
  parameter int XMAX     = 625,
  parameter int YLOSE    = 400,
  parameter int WAVE_GAP = 60,
  parameter int SCORE_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixpulse,
  input  logic                   move,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   bullet_pix,
  input  logic                   start,
  output logic                   draw_ene,
  output logic                   hit_pulse,
  output logic [COLS*ROWS-1:0]   alive,
  output logic [SCORE_W-1:0]     score,
  output logic [3:0]             wave,
  output logic                   wave_clear,
  output logic                   game_over
);

  localparam int N  = COLS * ROWS;
  localparam int GW = (WAVE_GAP > 1) ? $clog2(WAVE_GAP) : 1;
  localparam logic signed [12:0] SPAN_R = 13'((COLS - 1) * X_PITCH + ESIZE + STEP);
  localparam logic signed [12:0] SPAN_B = 13'((ROWS - 1) * Y_PITCH + ESIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2,
    LOSE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [N-1:0]         alive_r;
  logic [N-1:0]         inside_s;
  logic [N-1:0]         kill_s;
  logic [SCORE_W-1:0]   score_r;
  logic [3:0]           wave_r;
  logic signed [10:0]   xoff_r;
  logic [9:0]           yoff_r;
  logic                 dir_left_r;
  logic [GW-1:0]        gap_r;
  logic                 hit_pulse_r;
  logic                 play_s;
  logic                 show_s;
  logic                 wave_clear_s;
  logic                 game_over_s;
  logic signed [12:0]   base_x_s;
  logic signed [12:0]   base_y_s;
  logic signed [12:0]   hpos_s;
  logic signed [12:0]   vpos_s;
  logic                 wall_right_s;
  logic                 wall_left_s;
  logic                 lose_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + SCORE_W'(1);
    end
  endfunction

  // Geometry is done in 13-bit signed so a left-shifted formation compares correctly.
  assign base_x_s     = 13'(X0) + $signed({{2{xoff_r[10]}}, xoff_r});
  assign base_y_s     = 13'(Y0) + $signed({3'b000, yoff_r});
  assign hpos_s       = $signed({3'b000, hcount});
  assign vpos_s       = $signed({3'b000, vcount});
  assign wall_right_s = (base_x_s + SPAN_R) > 13'(XMAX);
  assign wall_left_s  = (base_x_s - 13'(STEP)) < 13'(XMIN);
  assign lose_s       = (base_y_s + SPAN_B) > 13'(YLOSE);

  // Per-enemy box test against the pixel currently being scanned out.
  always_comb begin
    inside_s = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      inside_s[k] = (hpos_s >= base_x_s + 13'((k % COLS) * X_PITCH)) &&
                    (hpos_s <  base_x_s + 13'((k % COLS) * X_PITCH + ESIZE)) &&
                    (vpos_s >= base_y_s + 13'((k / COLS) * Y_PITCH)) &&
                    (vpos_s <  base_y_s + 13'((k / COLS) * Y_PITCH + ESIZE));
    end
  end

  assign kill_s   = {N{play_s & pixpulse & bullet_pix}} & alive_r & inside_s;
  assign draw_ene = show_s & (|(alive_r & inside_s));

  // Wave state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wave transitions; a clear takes priority over the lose check.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = PLAY;
        else       next_state_s = IDLE;
      end
      PLAY: begin
        if (alive_r == {N{1'b0}}) next_state_s = CLEAR;
        else if (lose_s)          next_state_s = LOSE;
        else                      next_state_s = PLAY;
      end
      CLEAR: begin
        if (move && (gap_r == GW'(WAVE_GAP - 1))) next_state_s = PLAY;
        else                                      next_state_s = CLEAR;
      end
      LOSE: begin
        if (start) next_state_s = PLAY;
        else       next_state_s = LOSE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State decode for the datapath and status outputs.
  always_comb begin
    play_s       = 1'b0;
    show_s       = 1'b0;
    wave_clear_s = 1'b0;
    game_over_s  = 1'b0;
    case (state_r)
      PLAY:  begin play_s = 1'b1; show_s = 1'b1; end
      CLEAR: wave_clear_s = 1'b1;
      LOSE:  begin show_s = 1'b1; game_over_s = 1'b1; end
      default: begin
        play_s = 1'b0;
        show_s = 1'b0;
      end
    endcase
  end

  // Formation position, alive flags, score, wave and respawn gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_r     <= {N{1'b0}};
      score_r     <= {SCORE_W{1'b0}};
      wave_r      <= 4'd0;
      xoff_r      <= 11'sd0;
      yoff_r      <= 10'd0;
      dir_left_r  <= 1'b0;
      gap_r       <= {GW{1'b0}};
      hit_pulse_r <= 1'b0;
    end else begin
      hit_pulse_r <= 1'b0;
      case (state_r)
        IDLE, LOSE: begin
          if (start) begin
            alive_r    <= {N{1'b1}};
            xoff_r     <= 11'sd0;
            yoff_r     <= 10'd0;
            dir_left_r <= 1'b0;
            score_r    <= {SCORE_W{1'b0}};
            wave_r     <= 4'd0;
            gap_r      <= {GW{1'b0}};
          end
        end
        PLAY: begin
          if (move) begin
            if (!dir_left_r) begin
              if (wall_right_s) begin
                dir_left_r <= 1'b1;
                yoff_r     <= yoff_r + 10'(DROP);
              end else begin
                xoff_r <= xoff_r + 11'(STEP);
              end
            end else begin
              if (wall_left_s) begin
                dir_left_r <= 1'b0;
                yoff_r     <= yoff_r + 10'(DROP);
              end else begin
                xoff_r <= xoff_r - 11'(STEP);
              end
            end
          end
          if (|kill_s) begin
            alive_r     <= alive_r & ~kill_s;
            score_r     <= sat_inc(score_r);
            hit_pulse_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (move) begin
            if (gap_r == GW'(WAVE_GAP - 1)) begin
              alive_r    <= {N{1'b1}};
              xoff_r     <= 11'sd0;
              yoff_r     <= 10'd0;
              dir_left_r <= 1'b0;
              wave_r     <= wave_r + 4'd1;
              gap_r      <= {GW{1'b0}};
            end else begin
              gap_r <= gap_r + GW'(1);
            end
          end
        end
        default: hit_pulse_r <= 1'b0;
      endcase
    end
  end

  assign alive      = alive_r;
  assign score      = score_r;
  assign wave       = wave_r;
  assign hit_pulse  = hit_pulse_r;
  assign wave_clear = wave_clear_s;
  assign game_over  = game_over_s;

endmodule

// File: tb/tb_ene_formation.sv
// Bench for ene_formation: constant-expectation tables and sequences plus a randomized run
// compared every clock against an integer-arithmetic model of the formation rules.
module tb_ene_formation;
  localparam int COLS = 6, ROWS = 2, ES = 21, XP = 50, YP = 100, X0 = 30, Y0 = 100;
  localparam int STEP = 2, DROP = 10, XMIN = 5, XMAX = 625, YLOSE = 400, GAP = 60;

  logic clk = 1'b0;
  logic rst, pixpulse, move, bullet_pix, start;
  logic [9:0] hcount, vcount;
  logic draw_ene, hit_pulse, wave_clear, game_over;
  logic [11:0] alive;
  logic [7:0] score;
  logic [3:0] wave;
  logic draw3, hit3, clear3, over3;
  logic [11:0] alive3;
  logic [2:0] score3;
  logic [3:0] wave3;

  always #5 clk = ~clk;

  ene_formation dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .move(move), .hcount(hcount), .vcount(vcount),
    .bullet_pix(bullet_pix), .start(start), .draw_ene(draw_ene), .hit_pulse(hit_pulse),
    .alive(alive), .score(score), .wave(wave), .wave_clear(wave_clear), .game_over(game_over)
  );

  ene_formation #(.SCORE_W(3)) dut3 (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .move(move), .hcount(hcount), .vcount(vcount),
    .bullet_pix(bullet_pix), .start(start), .draw_ene(draw3), .hit_pulse(hit3),
    .alive(alive3), .score(score3), .wave(wave3), .wave_clear(clear3), .game_over(over3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 play, 2 clear, 3 lose.
  int m_state, m_xoff, m_yoff, m_score, m_wave, m_gap;
  bit [11:0] m_alive;
  bit m_left, m_hit;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_inside(input int k, input int h, input int v);
    int bx, by;
    bx = X0 + m_xoff + (k % COLS) * XP;
    by = Y0 + m_yoff + (k / COLS) * YP;
    return (h >= bx) && (h < bx + ES) && (v >= by) && (v < by + ES);
  endfunction

  function automatic bit m_draw(input int h, input int v);
    if (m_state != 1 && m_state != 3) return 1'b0;
    for (int k = 0; k < COLS * ROWS; k++)
      if (m_alive[k] && m_inside(k, h, v)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_xoff = 0; m_yoff = 0; m_score = 0; m_wave = 0; m_gap = 0;
    m_alive = '0; m_left = 0; m_hit = 0;
  endtask

  task automatic spawn(input bit fresh);
    m_alive = 12'hfff; m_xoff = 0; m_yoff = 0; m_left = 0; m_gap = 0; m_state = 1;
    if (fresh) begin m_score = 0; m_wave = 0; end
  endtask

  task automatic model_edge();
    int hk, ns;
    hk = -1;
    m_hit = 0;
    case (m_state)
      0, 3: if (start) spawn(1);
      1: begin
        if (pixpulse && bullet_pix)
          for (int k = 0; k < COLS * ROWS; k++)
            if (m_alive[k] && m_inside(k, hcount, vcount)) hk = k;
        ns = 1;
        if (m_alive == 0) ns = 2;
        else if (Y0 + m_yoff + (ROWS - 1) * YP + ES > YLOSE) ns = 3;
        if (move) begin
          if (!m_left) begin
            if (X0 + m_xoff + (COLS - 1) * XP + ES + STEP > XMAX) begin
              m_left = 1; m_yoff += DROP;
            end else m_xoff += STEP;
          end else begin
            if (X0 + m_xoff - STEP < XMIN) begin
              m_left = 0; m_yoff += DROP;
            end else m_xoff -= STEP;
          end
        end
        if (hk >= 0) begin m_alive[hk] = 0; m_score++; m_hit = 1; end
        if (ns == 2) m_gap = 0;
        m_state = ns;
      end
      2: if (move) begin
        if (m_gap == GAP - 1) begin spawn(0); m_wave = (m_wave + 1) % 16; end
        else m_gap++;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic check_all();
    chk("alive", alive, m_alive);
    chk("alive3", alive3, m_alive);
    chk("score", score, (m_score > 255) ? 255 : m_score);
    chk("score3", score3, (m_score > 7) ? 7 : m_score);
    chk("wave", wave, m_wave);
    chk("wave_clear", wave_clear, (m_state == 2) ? 1 : 0);
    chk("game_over", game_over, (m_state == 3) ? 1 : 0);
    chk("hit_pulse", hit_pulse, m_hit);
    chk("draw_ene", draw_ene, m_draw(hcount, vcount));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic shoot(input int h, input int v, input bit mv);
    hcount = 10'(h); vcount = 10'(v); pixpulse = 1'b1; bullet_pix = 1'b1; move = mv;
    cycle();
    pixpulse = 1'b0; bullet_pix = 1'b0; move = 1'b0;
  endtask

  task automatic probe(input string name, input int h, input int v, input int exp);
    hcount = 10'(h); vcount = 10'(v);
    cycle();
    chk(name, draw_ene, exp);
  endtask

  typedef struct { int h; int v; int exp; } probe_t;

  initial begin
    probe_t tbl[12];
    int steps, k, h, v;
    tbl[0]  = '{30, 100, 1};  tbl[1]  = '{50, 120, 1};  tbl[2]  = '{51, 100, 0};
    tbl[3]  = '{29, 100, 0};  tbl[4]  = '{80, 100, 1};  tbl[5]  = '{79, 110, 0};
    tbl[6]  = '{30, 200, 1};  tbl[7]  = '{30, 121, 0};  tbl[8]  = '{280, 220, 1};
    tbl[9]  = '{301, 220, 0}; tbl[10] = '{0, 0, 0};     tbl[11] = '{300, 199, 0};

    rst = 1'b0; pixpulse = 1'b0; move = 1'b0; bullet_pix = 1'b0; start = 1'b0;
    hcount = 10'd30; vcount = 10'd100;
    do_reset();
    chk("rst_alive", alive, 0);
    chk("rst_score", score, 0);
    chk("rst_draw", draw_ene, 0);

    pulse_start();
    chk("start_alive", alive, 12'hfff);
    for (int i = 0; i < 12; i++) probe("tbl_draw", tbl[i].h, tbl[i].v, tbl[i].exp);

    shoot(30, 100, 1'b0);
    chk("hit_alive", alive, 12'hffe);
    chk("hit_score", score, 1);
    chk("hit_pulse_on", hit_pulse, 1);
    cycle();
    chk("hit_pulse_off", hit_pulse, 0);
    shoot(30, 100, 1'b0);
    chk("rehit_alive", alive, 12'hffe);
    chk("rehit_score", score, 1);
    chk("rehit_pulse", hit_pulse, 0);

    move = 1'b1;
    for (int i = 0; i < 162; i++) cycle();
    move = 1'b0;
    probe("x324_in", 404, 100, 1);
    probe("x324_out", 403, 100, 0);
    move = 1'b1; cycle(); move = 1'b0;
    probe("drop_in", 404, 110, 1);
    probe("drop_out", 404, 109, 0);
    move = 1'b1; cycle(); move = 1'b0;
    probe("left_in", 402, 110, 1);
    probe("left_out", 401, 110, 0);

    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) shoot(X0 + (i % COLS) * XP, Y0 + (i / COLS) * YP, 1'b0);
    chk("killall_alive", alive, 0);
    cycle();
    chk("clear_on", wave_clear, 1);
    chk("clear_score", score, 12);
    chk("clear_score3", score3, 7);
    move = 1'b1;
    for (int i = 0; i < 59; i++) cycle();
    move = 1'b0;
    chk("gap59_clear", wave_clear, 1);
    move = 1'b1; cycle(); move = 1'b0;
    chk("respawn_alive", alive, 12'hfff);
    chk("respawn_wave", wave, 1);
    chk("respawn_score", score, 12);
    chk("respawn_clear", wave_clear, 0);

    shoot(30, 100, 1'b1);
    chk("hitmove_alive", alive, 12'hffe);
    chk("hitmove_score", score, 13);
    probe("hitmove_in", 32, 200, 1);
    probe("hitmove_out", 31, 200, 0);

    move = 1'b1;
    steps = 0;
    while (!game_over && steps < 6000) begin cycle(); steps++; end
    move = 1'b0;
    chk("lose_reached", game_over, 1);
    for (int i = 0; i < 4; i++) shoot(X0 + m_xoff + XP + 3, Y0 + m_yoff + 3, 1'b1);
    chk("lose_frozen", alive, 12'hffe);
    chk("lose_score", score, 13);
    pulse_start();
    chk("restart_over", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_alive", alive, 12'hfff);

    probe("mid_draw", 30, 100, 1);
    do_reset();
    chk("mid_rst_alive", alive, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_draw", draw_ene, 0);

    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, COLS * ROWS - 1);
      h = X0 + m_xoff + (k % COLS) * XP + $urandom_range(0, ES + 3) - 2;
      v = Y0 + m_yoff + (k / COLS) * YP + $urandom_range(0, ES + 3) - 2;
      if (h < 0) h = 0;
      if (h > 1023) h = 1023;
      if (v > 1023) v = 1023;
      hcount = 10'(h); vcount = 10'(v);
      pixpulse = ($urandom_range(0, 3) == 0);
      bullet_pix = ($urandom_range(0, 2) == 0);
      move = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 49) == 0);
      cycle();
    end
    pixpulse = 1'b0; bullet_pix = 1'b0; move = 1'b0; start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end
endmodule
